hash_bits_off_pipe: RTL and testbench
=====================================

// Module: hash_bits_off_pipe
// PURPOSE
//  Pipelined, parametrised Hamming-distance ("bits off") engine: XORs each WIDTH-bit hash
//  against a loaded target, population-counts the result and tracks the best (lowest)
//  distance seen. Sits after the hash core, one result per clock, no stalls.
//  Exports the running minimum, the tag of the hash that produced it and a threshold-hit flag.
// PARAMETERS
//  WIDTH   1024  hash/target width in bits
//  TAG_W   32    width of the sideband tag (nonce/candidate id) carried with each hash
//  CHUNK   6     bits per first-level LUT popcount (fixed 6 in this generation; 3-bit count out)
//  derived: NCHUNK=ceil(WIDTH/CHUNK), LAT=1+clog2(NCHUNK), CNT_W=clog2(WIDTH+1) (1024 -> 9, 11)
// PORTS
//  clk_i           in   1      clock, all logic rising-edge
//  rst_n_i         in   1      asynchronous active-low reset
//  target_we_i     in   1      load target_i into target register
//  target_i        in   WIDTH  target pattern
//  valid_i         in   1      hash_i/tag_i valid this cycle
//  hash_i          in   WIDTH  hash to score
//  tag_i           in   TAG_W  sideband tag, travels with hash
//  thresh_i        in   CNT_W  hit threshold (static, sampled at output stage)
//  clear_i         in   1      sync clear of best-so-far and result counter
//  valid_o         out  1      dist_o/tag_o valid
//  dist_o          out  CNT_W  popcount(hash ^ target)
//  tag_o           out  TAG_W  tag matching dist_o
//  hit_o           out  1      valid_o && dist_o <= thresh_i
//  best_dist_o     out  CNT_W  lowest distance since reset/clear
//  best_tag_o      out  TAG_W  tag of best_dist_o
//  best_upd_o      out  1      one-cycle pulse: best registers changed this cycle
//  result_cnt_o    out  32     number of valid results since reset/clear, saturating
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): target=0, all valid bits 0, dist_o=0,
//   tag_o=0, hit_o=0, best_dist_o=WIDTH (sentinel, worse than any real result),
//   best_tag_o=0, best_upd_o=0, result_cnt_o=0. In-flight samples are discarded.
//  Pipeline: stage 0 registers XOR chunk counts (NCHUNK x 3 bits, last chunk zero-padded);
//   stages 1..LAT-1 each register one level of a pairwise adder tree (odd element passes
//   through). valid/tag shift alongside. Fixed latency LAT: valid_i at cycle N -> valid_o at N+LAT.
//  Never stalls; no backpressure. Data/tag regs need no reset; valid chain does.
//  Target: target_we_i loads at clock edge; a sample with valid_i in the same cycle uses the
//   OLD target. Samples already in flight are unaffected by a target load.
//  Best tracking (registered at output+1, i.e. best_* update at N+LAT+1):
//   update iff valid_o && dist_o < best_dist_o (strict; ties keep earlier tag).
//   clear_i: best_dist<=WIDTH, best_tag<=0, count<=0, then same cycle valid_o result is
//   evaluated against the sentinel (clear then compare): best loads it, best_upd_o=1, count=1.
//  best_upd_o high exactly the cycle after a best change; never on clear alone.
//  result_cnt_o increments on valid_o, saturates at 2^32-1.
//  dist_o = WIDTH possible (all bits differ); never compares lower than sentinel spuriously.
// STRUCTURE
//  Package hash_bits_off_pkg: clog2 function, CHUNK constant, default WIDTH/TAG_W,
//   derived NCHUNK/LAT/CNT_W localparam helpers.
//  Sub-module hash_bits_off_chunk_cnt: combinational 6-bit -> 3-bit popcount (LUT_MAP),
//   instantiated NCHUNK times by generate. Adder tree via generate loop in this module.
// TESTING
//  1 hash=target=all-ones, then hash=~target -> dist_o=0 then 1024, each exactly LAT=9 cycles later.
//  2 Back-to-back stream of 200 random hashes, valid_i every cycle -> dist_o matches model
//    popcount, order and tags preserved, result_cnt_o=200.
//  3 target_we_i with valid_i same cycle (target 0 -> all-ones, hash 0) -> dist 0 (old target);
//    next sample hash 0 -> dist 1024.
//  4 dists 500,300,300,700,299 -> best 500,300,300(first tag kept),300,299; best_upd_o on 3 of 5.
//  5 clear_i coincident with valid_o dist=800 (best=100) -> best_dist_o=800, best_upd_o=1, count=1.
//  6 rst_n_i low mid-stream with 5 in flight -> outputs reset values immediately, no valid_o
//    after release until new input; thresh_i=10 with dist 10/11 -> hit_o 1/0.

Source files
------------

// File: rtl/hash_bits_off_pkg.sv
// rtl/hash_bits_off_pkg.sv - shared constants and derived-size helpers for the bits-off engine
package hash_bits_off_pkg;

   localparam int CHUNK       = 6;
   localparam int CHUNK_CNT_W = 3;
   localparam int DEF_WIDTH   = 1024;
   localparam int DEF_TAG_W   = 32;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int nchunk(input int w);
      return (w + CHUNK - 1) / CHUNK;
   endfunction

   function automatic int lat(input int w);
      return 1 + clog2(nchunk(w));
   endfunction

   function automatic int cnt_w(input int w);
      return clog2(w + 1);
   endfunction

endpackage

// File: rtl/hash_bits_off_pipe_if.sv
// rtl/hash_bits_off_pipe_if.sv - hash/target in, distance/best-so-far out
interface hash_bits_off_pipe_if
   import hash_bits_off_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W,
   parameter int CNT_W = cnt_w(WIDTH)
);
   logic             target_we_i;
   logic [WIDTH-1:0] target_i;
   logic             valid_i;
   logic [WIDTH-1:0] hash_i;
   logic [TAG_W-1:0] tag_i;
   logic [CNT_W-1:0] thresh_i;
   logic             clear_i;
   logic             valid_o;
   logic [CNT_W-1:0] dist_o;
   logic [TAG_W-1:0] tag_o;
   logic             hit_o;
   logic [CNT_W-1:0] best_dist_o;
   logic [TAG_W-1:0] best_tag_o;
   logic             best_upd_o;
   logic [31:0]      result_cnt_o;

   modport slave (
      input  target_we_i, target_i, valid_i, hash_i, tag_i, thresh_i, clear_i,
      output valid_o, dist_o, tag_o, hit_o, best_dist_o, best_tag_o, best_upd_o, result_cnt_o
   );

   modport master (
      output target_we_i, target_i, valid_i, hash_i, tag_i, thresh_i, clear_i,
      input  valid_o, dist_o, tag_o, hit_o, best_dist_o, best_tag_o, best_upd_o, result_cnt_o
   );
endinterface

// File: rtl/hash_bits_off_chunk_cnt.sv
// rtl/hash_bits_off_chunk_cnt.sv - combinational 6-bit to 3-bit popcount leaf
module hash_bits_off_chunk_cnt
   import hash_bits_off_pkg::*;
(
   input  logic [CHUNK-1:0]       i_bits,
   output logic [CHUNK_CNT_W-1:0] o_cnt
);

   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < CHUNK; i++) begin
         o_cnt = o_cnt + CHUNK_CNT_W'(i_bits[i]);
      end
   end

endmodule

// File: rtl/hash_bits_off_pipe.sv
// rtl/hash_bits_off_pipe.sv - pipelined Hamming distance with running-minimum tracking
module hash_bits_off_pipe
   import hash_bits_off_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W
)(
   input  logic clk_i,
   input  logic rst_n_i,
   hash_bits_off_pipe_if.slave bus
);

   localparam int NCHUNK = nchunk(WIDTH);
   localparam int LAT    = lat(WIDTH);
   localparam int CNT_W  = cnt_w(WIDTH);
   localparam int XW     = NCHUNK * CHUNK;
   localparam int NP     = 2 * ((NCHUNK + 1) / 2);
   localparam logic [CNT_W-1:0] SENTINEL = CNT_W'(WIDTH);

   logic [WIDTH-1:0]       r_target;
   logic [XW-1:0]          w_xpad;
   logic [CHUNK_CNT_W-1:0] w_cnt [NCHUNK];
   logic [CNT_W-1:0]       r_tree [LAT][NP];
   logic [TAG_W-1:0]       r_tag [LAT];
   logic [LAT-1:0]         r_vld;

   logic                   w_out_vld;
   logic [CNT_W-1:0]       w_dist;
   logic [CNT_W-1:0]       w_cmp_base;
   logic [31:0]            w_cnt_base;
   logic                   w_better;
   logic [CNT_W-1:0]       r_best_dist;
   logic [TAG_W-1:0]       r_best_tag;
   logic                   r_best_upd;
   logic [31:0]            r_result_cnt;

   assign w_xpad = XW'(bus.hash_i ^ r_target);

   for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
      hash_bits_off_chunk_cnt u_cnt (
         .i_bits (w_xpad[c*CHUNK +: CHUNK]),
         .o_cnt  (w_cnt[c])
      );
   end

   // Tree rows are padded to an even length with zeros, so an odd leftover
   // element passes through as "x + 0" instead of needing its own mux.
   always_ff @(posedge clk_i) begin
      for (int e = 0; e < NCHUNK; e++) r_tree[0][e] <= CNT_W'(w_cnt[e]);
      if (NP > NCHUNK) r_tree[0][NP-1] <= '0;
      for (int l = 1; l < LAT; l++) begin
         for (int e = 0; e < NP / 2; e++) r_tree[l][e] <= r_tree[l-1][2*e] + r_tree[l-1][2*e+1];
         for (int e = NP / 2; e < NP; e++) r_tree[l][e] <= '0;
      end
      r_tag[0] <= bus.tag_i;
      for (int l = 1; l < LAT; l++) r_tag[l] <= r_tag[l-1];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_target <= '0;
         r_vld    <= '0;
      end else begin
         if (bus.target_we_i) r_target <= bus.target_i;
         r_vld <= LAT'({r_vld, bus.valid_i});
      end
   end

   assign w_out_vld = r_vld[LAT-1];
   assign w_dist    = r_tree[LAT-1][0];

   assign bus.valid_o = w_out_vld;
   assign bus.dist_o  = w_out_vld ? w_dist : '0;
   assign bus.tag_o   = w_out_vld ? r_tag[LAT-1] : '0;
   assign bus.hit_o   = w_out_vld && (w_dist <= bus.thresh_i);

   // Clear takes effect before the compare, so a result arriving with clear
   // is scored against the sentinel and always becomes the new best.
   assign w_cmp_base = bus.clear_i ? SENTINEL : r_best_dist;
   assign w_cnt_base = bus.clear_i ? 32'd0 : r_result_cnt;
   assign w_better   = w_out_vld && (w_dist < w_cmp_base);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_best_dist  <= SENTINEL;
         r_best_tag   <= '0;
         r_best_upd   <= 1'b0;
         r_result_cnt <= '0;
      end else begin
         r_best_upd <= w_better;
         if (w_better) begin
            r_best_dist <= w_dist;
            r_best_tag  <= r_tag[LAT-1];
         end else if (bus.clear_i) begin
            r_best_dist <= SENTINEL;
            r_best_tag  <= '0;
         end
         if (w_out_vld && (w_cnt_base != '1)) r_result_cnt <= w_cnt_base + 32'd1;
         else                                 r_result_cnt <= w_cnt_base;
      end
   end

   assign bus.best_dist_o  = r_best_dist;
   assign bus.best_tag_o   = r_best_tag;
   assign bus.best_upd_o   = r_best_upd;
   assign bus.result_cnt_o = r_result_cnt;

endmodule

// File: tb/tb_hash_bits_off_pipe.sv
// tb/tb_hash_bits_off_pipe.sv - randomized self-checking bench for hash_bits_off_pipe
module tb_hash_bits_off_pipe;

   localparam int W   = 1024;
   localparam int TW  = 32;
   localparam int CW  = 11;
   localparam int LAT = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   n_upd = 0;
   logic prev_v = 1'b0;
   logic [W-1:0] m_target = '0;

   int          q_dist[$];
   logic [TW-1:0] q_tag[$];
   int          q_cyc[$];
   logic        q_hit[$];
   int          q_bdist[$];
   logic [TW-1:0] q_btag[$];

   hash_bits_off_pipe_if #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) bus ();

   hash_bits_off_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (prev_v) begin
         q_bdist.push_back(int'(bus.best_dist_o));
         q_btag.push_back(bus.best_tag_o);
      end
      if (bus.best_upd_o === 1'b1) n_upd++;
      if (bus.valid_o === 1'b1) begin
         q_dist.push_back(int'(bus.dist_o));
         q_tag.push_back(bus.tag_o);
         q_cyc.push_back(cyc);
         q_hit.push_back(bus.hit_o);
      end
      prev_v = (bus.valid_o === 1'b1);
   end

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [W-1:0] with_dist(input logic [W-1:0] base, input int d);
      logic [W-1:0] mask;
      int n;
      int idx;
      mask = '0;
      n = 0;
      while (n < d) begin
         idx = $urandom_range(W - 1, 0);
         if (!mask[idx]) begin
            mask[idx] = 1'b1;
            n++;
         end
      end
      return base ^ mask;
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] h, input logic [TW-1:0] t,
                        input logic we, input logic [W-1:0] tg, input logic clr);
      @(posedge clk);
      #1;
      bus.valid_i     = v;
      bus.hash_i      = h;
      bus.tag_i       = t;
      bus.target_we_i = we;
      bus.target_i    = tg;
      bus.clear_i     = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.valid_o); end
      n_cmp++; if (bus.dist_o !== '0) begin n_err++; $display("FAIL reset_dist got %0d want 0", bus.dist_o); end
      n_cmp++; if (bus.tag_o !== '0) begin n_err++; $display("FAIL reset_tag got %0h want 0", bus.tag_o); end
      n_cmp++; if (bus.hit_o !== 1'b0) begin n_err++; $display("FAIL reset_hit got %0b want 0", bus.hit_o); end
      n_cmp++; if (bus.best_dist_o !== CW'(W)) begin n_err++; $display("FAIL reset_best_dist got %0d want %0d", bus.best_dist_o, W); end
      n_cmp++; if (bus.best_tag_o !== '0) begin n_err++; $display("FAIL reset_best_tag got %0h want 0", bus.best_tag_o); end
      n_cmp++; if (bus.best_upd_o !== 1'b0) begin n_err++; $display("FAIL reset_best_upd got %0b want 0", bus.best_upd_o); end
      n_cmp++; if (bus.result_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.result_cnt_o); end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_extremes();
      int b;
      int c0;
      int c1;
      drive(1'b0, '0, '0, 1'b1, '1, 1'b0);
      m_target = '1;
      b = q_dist.size();
      drive(1'b1, '1, 32'h11, 1'b0, '0, 1'b0); c0 = cyc;
      drive(1'b1, ~m_target, 32'h22, 1'b0, '0, 1'b0); c1 = cyc;
      idle(LAT + 2);
      n_cmp++;
      if (q_dist.size() - b != 2) begin
         n_err++; $display("FAIL ext_count got %0d want 2", q_dist.size() - b);
      end else begin
         n_cmp++; if (q_dist[b] != 0) begin n_err++; $display("FAIL ext_dist0 got %0d want 0", q_dist[b]); end
         n_cmp++; if (q_dist[b+1] != W) begin n_err++; $display("FAIL ext_dist1 got %0d want %0d", q_dist[b+1], W); end
         n_cmp++; if (q_tag[b] !== 32'h11 || q_tag[b+1] !== 32'h22) begin n_err++; $display("FAIL ext_tags got %0h/%0h want 11/22", q_tag[b], q_tag[b+1]); end
         n_cmp++; if (q_cyc[b] - c0 != LAT) begin n_err++; $display("FAIL ext_lat0 got %0d want %0d", q_cyc[b] - c0, LAT); end
         n_cmp++; if (q_cyc[b+1] - c1 != LAT) begin n_err++; $display("FAIL ext_lat1 got %0d want %0d", q_cyc[b+1] - c1, LAT); end
      end
   endtask

   task automatic test_back_to_back();
      int b;
      int exp_d[$];
      logic [TW-1:0] exp_t[$];
      int best;
      logic [TW-1:0] btag;
      logic [W-1:0] tg;
      logic [W-1:0] h;
      logic [TW-1:0] t;
      tg = rand_vec();
      drive(1'b0, '0, '0, 1'b1, tg, 1'b1);
      m_target = tg;
      b = q_dist.size();
      best = W;
      btag = '0;
      for (int i = 0; i < 200; i++) begin
         h = rand_vec();
         t = $urandom;
         exp_d.push_back($countones(h ^ m_target));
         exp_t.push_back(t);
         if (exp_d[i] < best) begin best = exp_d[i]; btag = t; end
         drive(1'b1, h, t, 1'b0, '0, 1'b0);
      end
      idle(LAT + 2);
      n_cmp++;
      if (q_dist.size() - b != 200) begin
         n_err++; $display("FAIL b2b_count got %0d want 200", q_dist.size() - b);
      end else begin
         for (int i = 0; i < 200; i++) begin
            n_cmp++;
            if (q_dist[b+i] != exp_d[i] || q_tag[b+i] !== exp_t[i]) begin
               n_err++;
               $display("FAIL b2b_item%0d got %0d/%0h want %0d/%0h", i, q_dist[b+i], q_tag[b+i], exp_d[i], exp_t[i]);
            end
         end
      end
      n_cmp++; if (bus.result_cnt_o !== 32'd200) begin n_err++; $display("FAIL b2b_cnt got %0d want 200", bus.result_cnt_o); end
      n_cmp++; if (int'(bus.best_dist_o) != best || bus.best_tag_o !== btag) begin n_err++; $display("FAIL b2b_best got %0d/%0h want %0d/%0h", bus.best_dist_o, bus.best_tag_o, best, btag); end
   endtask

   task automatic test_target_same_cycle();
      int b;
      int e0;
      int e1;
      drive(1'b0, '0, '0, 1'b1, '0, 1'b0);
      m_target = '0;
      b = q_dist.size();
      e0 = $countones({W{1'b0}} ^ m_target);
      drive(1'b1, '0, 32'hA1, 1'b1, '1, 1'b0);
      m_target = '1;
      e1 = $countones({W{1'b0}} ^ m_target);
      drive(1'b1, '0, 32'hA2, 1'b0, '0, 1'b0);
      idle(LAT + 2);
      n_cmp++;
      if (q_dist.size() - b != 2) begin
         n_err++; $display("FAIL tgt_count got %0d want 2", q_dist.size() - b);
      end else begin
         n_cmp++; if (q_dist[b] != e0) begin n_err++; $display("FAIL tgt_old got %0d want %0d", q_dist[b], e0); end
         n_cmp++; if (q_dist[b+1] != e1) begin n_err++; $display("FAIL tgt_new got %0d want %0d", q_dist[b+1], e1); end
      end
   endtask

   task automatic test_best_tracking();
      int dists[5] = '{500, 300, 300, 700, 299};
      int b;
      int u;
      int bst;
      int ups;
      logic [TW-1:0] btag;
      int exp_b[5];
      logic [TW-1:0] exp_bt[5];
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      b = q_bdist.size();
      u = n_upd;
      bst = W;
      btag = '0;
      ups = 0;
      for (int i = 0; i < 5; i++) begin
         if (dists[i] < bst) begin bst = dists[i]; btag = TW'(10 + i); ups++; end
         exp_b[i] = bst;
         exp_bt[i] = btag;
         drive(1'b1, with_dist(m_target, dists[i]), TW'(10 + i), 1'b0, '0, 1'b0);
      end
      idle(LAT + 3);
      n_cmp++;
      if (q_bdist.size() - b != 5) begin
         n_err++; $display("FAIL best_count got %0d want 5", q_bdist.size() - b);
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (q_bdist[b+i] != exp_b[i] || q_btag[b+i] !== exp_bt[i]) begin
               n_err++;
               $display("FAIL best_step%0d got %0d/%0h want %0d/%0h", i, q_bdist[b+i], q_btag[b+i], exp_b[i], exp_bt[i]);
            end
         end
      end
      n_cmp++; if (n_upd - u != ups) begin n_err++; $display("FAIL best_upd_pulses got %0d want %0d", n_upd - u, ups); end
   endtask

   task automatic test_clear();
      int u;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      drive(1'b1, with_dist(m_target, 100), 32'h100, 1'b0, '0, 1'b0);
      idle(LAT + 2);
      @(negedge clk);
      n_cmp++; if (bus.best_dist_o !== CW'(100)) begin n_err++; $display("FAIL clr_pre_best got %0d want 100", bus.best_dist_o); end
      u = n_upd;
      drive(1'b1, with_dist(m_target, 800), 32'h800, 1'b0, '0, 1'b0);
      idle(LAT - 1);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      n_cmp++; if (bus.best_dist_o !== CW'(800)) begin n_err++; $display("FAIL clr_best_dist got %0d want 800", bus.best_dist_o); end
      n_cmp++; if (bus.best_tag_o !== 32'h800) begin n_err++; $display("FAIL clr_best_tag got %0h want 800", bus.best_tag_o); end
      n_cmp++; if (bus.best_upd_o !== 1'b1) begin n_err++; $display("FAIL clr_best_upd got %0b want 1", bus.best_upd_o); end
      n_cmp++; if (bus.result_cnt_o !== 32'd1) begin n_err++; $display("FAIL clr_cnt got %0d want 1", bus.result_cnt_o); end
      idle(3);
      n_cmp++; if (n_upd - u != 1) begin n_err++; $display("FAIL clr_pulses got %0d want 1", n_upd - u); end
   endtask

   task automatic test_reset_midstream();
      int b;
      for (int i = 0; i < 5; i++) drive(1'b1, rand_vec(), TW'(32'h500 + i), 1'b0, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      bus.valid_i = 1'b0;
      m_target = '0;
      #1;
      n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL mid_valid got %0b want 0", bus.valid_o); end
      n_cmp++; if (bus.best_dist_o !== CW'(W)) begin n_err++; $display("FAIL mid_best got %0d want %0d", bus.best_dist_o, W); end
      n_cmp++; if (bus.result_cnt_o !== 32'd0) begin n_err++; $display("FAIL mid_cnt got %0d want 0", bus.result_cnt_o); end
      n_cmp++; if (bus.best_tag_o !== '0 || bus.best_upd_o !== 1'b0) begin n_err++; $display("FAIL mid_btag got %0h/%0b want 0/0", bus.best_tag_o, bus.best_upd_o); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      b = q_dist.size();
      idle(LAT + 3);
      n_cmp++; if (q_dist.size() != b) begin n_err++; $display("FAIL mid_ghost got %0d want 0", q_dist.size() - b); end
      bus.thresh_i = CW'(10);
      drive(1'b1, with_dist(m_target, 10), 32'h1, 1'b0, '0, 1'b0);
      drive(1'b1, with_dist(m_target, 11), 32'h2, 1'b0, '0, 1'b0);
      idle(LAT + 2);
      n_cmp++;
      if (q_hit.size() - b != 2) begin
         n_err++; $display("FAIL hit_count got %0d want 2", q_hit.size() - b);
      end else begin
         n_cmp++; if (q_hit[b] !== (q_dist[b] <= 10) || q_dist[b] != 10) begin n_err++; $display("FAIL hit_10 got %0b/%0d want 1/10", q_hit[b], q_dist[b]); end
         n_cmp++; if (q_hit[b+1] !== (q_dist[b+1] <= 10) || q_dist[b+1] != 11) begin n_err++; $display("FAIL hit_11 got %0b/%0d want 0/11", q_hit[b+1], q_dist[b+1]); end
      end
   endtask

   initial begin
      bus.target_we_i = 1'b0;
      bus.target_i    = '0;
      bus.valid_i     = 1'b0;
      bus.hash_i      = '0;
      bus.tag_i       = '0;
      bus.thresh_i    = '0;
      bus.clear_i     = 1'b0;
      test_reset();
      test_extremes();
      test_back_to_back();
      test_target_same_cycle();
      test_best_tracking();
      test_clear();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
